// File: rtl/dec_3x8_reg_if.sv
// rtl/dec_3x8_reg_if.sv - control/output bundle for the registered 3-to-8 decoder
//
// Purpose : groups the decoder control inputs and registered outputs so they
//           travel together between the driver and the decoder.
// Signals : en, load, a[2:0], pulse_mode, scan  (driver -> decoder)
//           y[7:0], valid, busy                  (decoder -> driver)
// Modports: master = driver side, slave = decoder side.
interface dec_3x8_reg_if;
    logic       en;
    logic       load;
    logic [2:0] a;
    logic       pulse_mode;
    logic       scan;
    logic [7:0] y;
    logic       valid;
    logic       busy;

    modport master (
        output en, load, a, pulse_mode, scan,
        input  y, valid, busy
    );

    modport slave (
        input  en, load, a, pulse_mode, scan,
        output y, valid, busy
    );
endinterface

// File: rtl/dec_3x8_reg.sv
// rtl/dec_3x8_reg.sv - registered 3-to-8 decoder with latch, pulse and scan modes
//
// Purpose : captures a 3-bit code on an accepted load and drives the matching
//           one-hot byte, either held (latch), for HOLD_CYCLES cycles (pulse),
//           or walks y[0]..y[7] continuously while scan is high.
// Params  : HOLD_CYCLES - cycles y stays non-zero in pulse mode (1..255).
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - slave side of dec_3x8_reg_if (controls in, y/valid/busy out)
module dec_3x8_reg #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dec_3x8_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_ok;

    // Loads arriving mid-pulse are dropped, not queued.
    assign load_ok = bus.load && bus.en && !bus.scan && (state_q != ST_PULSE);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;

        if (!bus.en) begin
            state_d = ST_IDLE;
            y_d     = 8'h00;
            cnt_d   = 8'd0;
        end else if (bus.scan) begin
            state_d = ST_SCAN;
            cnt_d   = 8'd0;
            // Entering scan always starts on line 0; staying in scan rotates left.
            if (state_q == ST_SCAN) begin
                y_d = {y_q[6:0], y_q[7]};
            end else begin
                y_d = 8'h01;
            end
        end else if (load_ok) begin
            y_d = 8'h01 << bus.a;
            if (bus.pulse_mode) begin
                state_d = ST_PULSE;
                // The load edge itself is the first of the HOLD_CYCLES visible cycles.
                cnt_d   = 8'(HOLD_CYCLES - 1);
            end else begin
                state_d = ST_LATCH;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    y_d = 8'h00;
                end
                ST_LATCH: begin
                    y_d = y_q;
                end
                ST_PULSE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                        y_d     = 8'h00;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_SCAN: begin
                    // scan dropped with no load in the same cycle
                    state_d = ST_IDLE;
                    y_d     = 8'h00;
                end
                default: begin
                    state_d = ST_IDLE;
                    y_d     = 8'h00;
                end
            endcase
        end

        valid_d = |y_d;
        busy_d  = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dec_3x8_reg.sv
// tb/tb_dec_3x8_reg.sv - self-checking bench for dec_3x8_reg
module tb_dec_3x8_reg;

    localparam int H = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dec_3x8_reg_if bus();

    dec_3x8_reg #(.HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode number, active line index, cycles of visibility left.
    localparam int M_IDLE  = 0;
    localparam int M_LATCH = 1;
    localparam int M_PULSE = 2;
    localparam int M_SCAN  = 3;
    int m_mode;
    int m_line;
    int m_left;

    function automatic logic [7:0] m_y();
        if (m_mode == M_IDLE) return 8'h00;
        return 8'(1 << m_line);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_line = 0;
        m_left = 0;
    endtask

    task automatic model_edge();
        if (!bus.en) begin
            m_mode = M_IDLE;
        end else if (bus.scan) begin
            m_line = (m_mode == M_SCAN) ? (m_line + 1) % 8 : 0;
            m_mode = M_SCAN;
        end else if (bus.load && m_mode != M_PULSE) begin
            m_line = int'(bus.a);
            m_mode = bus.pulse_mode ? M_PULSE : M_LATCH;
            m_left = H;
        end else if (m_mode == M_PULSE) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_IDLE;
        end else if (m_mode == M_SCAN) begin
            m_mode = M_IDLE;
        end
    endtask

    function automatic logic [2:0] enc_8x3(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".y"},     bus.y,            m_y());
        chk({name, ".valid"}, {7'd0, bus.valid}, {7'd0, m_y() != 8'h00});
        chk({name, ".busy"},  {7'd0, bus.busy},  {7'd0, m_mode == M_PULSE});
    endtask

    // Advance one rising edge, track the model, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic drive(input logic en, input logic load, input logic [2:0] a,
                         input logic pm, input logic scan);
        bus.en = en; bus.load = load; bus.a = a; bus.pulse_mode = pm; bus.scan = scan;
    endtask

    typedef struct {
        logic       en;
        logic       load;
        logic [2:0] a;
        logic       pm;
        logic       scan;
        logic [7:0] ey;
        logic       eb;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic load, input logic [2:0] a, input logic pm,
                       input logic scan, input logic [7:0] ey, input logic eb, input string name);
        vec_t v;
        v.en = en; v.load = load; v.a = a; v.pm = pm; v.scan = scan;
        v.ey = ey; v.eb = eb; v.name = name;
        vq.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        // Reset holds outputs idle even with a load pending.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset.y", bus.y, 8'h00);
            chk("reset.valid", {7'd0, bus.valid}, 8'h00);
            chk("reset.busy", {7'd0, bus.busy}, 8'h00);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle.y", bus.y, 8'h00);
        end

        // Latch sweep, en=0, pulse with ignored load, scan wrap, scan abort of pulse.
        for (int i = 0; i < 8; i++) add(1, 1, 3'(i), 0, 0, 8'(1 << i), 0, "latch_sweep");
        add(0, 0, 0, 0, 0, 8'h00, 0, "latch_en_off");
        add(1, 1, 3, 1, 0, 8'h08, 1, "pulse_c1");
        add(1, 0, 3, 1, 0, 8'h08, 1, "pulse_c2");
        add(1, 1, 6, 1, 0, 8'h08, 1, "pulse_c3_ignored_load");
        add(1, 0, 0, 0, 0, 8'h08, 1, "pulse_c4");
        add(1, 0, 0, 0, 0, 8'h00, 0, "pulse_end");
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 1, 8'(1 << (i % 8)), 0, "scan_walk");
        add(1, 1, 4, 0, 0, 8'h10, 0, "scan_exit_load");
        add(1, 1, 2, 1, 0, 8'h04, 1, "abort_pulse_start");
        add(1, 0, 2, 1, 1, 8'h01, 0, "abort_by_scan");
        add(0, 0, 0, 0, 1, 8'h00, 0, "en_over_scan");

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].load, vq[i].a, vq[i].pm, vq[i].scan);
            step();
            chk({vq[i].name, ".y"}, bus.y, vq[i].ey);
            chk({vq[i].name, ".valid"}, {7'd0, bus.valid}, {7'd0, vq[i].ey != 8'h00});
            chk({vq[i].name, ".busy"}, {7'd0, bus.busy}, {7'd0, vq[i].eb});
        end

        // Asynchronous reset in the middle of a latched code.
        drive(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
        step();
        chk("pre_reset.y", bus.y, 8'h40);
        drive(1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset.y", bus.y, 8'h00);
        chk("async_reset.valid", {7'd0, bus.valid}, 8'h00);
        model_reset();
        #1 rst_n = 1'b1;

        // Loop-back through an 8x3 encoder.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 3'(k), 1'b0, 1'b0);
            step();
            chk("loopback.enc", {5'd0, enc_8x3(bus.y)}, 8'(k));
            chk_model("loopback");
        end

        // Load held high in pulse mode: one idle cycle between pulses.
        drive(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 2 * H + 2; i++) begin
            step();
            chk_model("b2b");
            if (i == H)     chk("b2b.gap_zero", bus.y, 8'h00);
            if (i == H + 1) chk("b2b.reload", bus.y, 8'h02);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) != 0, ($urandom % 2) == 1, 3'($urandom_range(0, 7)),
                  ($urandom % 2) == 1, ($urandom % 6) == 0);
            step();
            chk_model("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
